window_read_addr_gen: RTL and testbench
=======================================

Name: window_read_addr_gen

Overview:
- Datapath stage directly downstream of the read-address controller FSM.
- Consumes its load_registers strobe (port load_en) and returns the can_count qualifier it needs.
- Generates sliding-window read addresses into a circular input buffer of depth 2^ADDR_W.
- Releases consumed entries back to the buffer writer.
- One address per qualified cycle; stride-advancing windows until num_windows windows are complete.

Parameters:
- ADDR_W, 4, buffer address width; depth = 2^ADDR_W.
- SIZE_W, 4, width of filter_size and stride.
- WIN_W, 8, width of the window counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  one-cycle job start pulse; sampled in IDLE only.
- filter_size  in  SIZE_W  reads per window; latched at start.
- stride  in  SIZE_W  base advance per window; latched at start.
- num_windows  in  WIN_W  windows per job; latched at start.
- wr_count  in  ADDR_W+1  valid entries in the buffer counted from base_ptr.
- rd_ready  in  1  buffer read port and consumer can accept an address.
- load_en  in  1  advance strobe from the controller.
- can_count  out  1  combinational; an address may issue this cycle.
- rd_addr  out  ADDR_W  registered read address.
- rd_valid  out  1  registered; rd_addr is valid.
- window_done  out  1  one-cycle pulse aligned with the last rd_valid of a window.
- free_en  out  1  one-cycle pulse; writer may release free_cnt entries.
- free_cnt  out  SIZE_W  entries released; equals the latched stride.
- busy  out  1  state == RUN.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset is synchronous, active-high on rst; clock is clk.
- Reset values: rd_addr=0, rd_valid=0, window_done=0, free_en=0, free_cnt=0, done=0, busy=0. Internal base_ptr=0, offset=0, win_cnt=0, state=IDLE.
- States:
  - IDLE: on start with filter_size, stride and num_windows all non-zero, latch the three fields, clear base_ptr, offset and win_cnt, and go to RUN.
  - Degenerate start: if any of the three fields is 0, stay in IDLE and pulse done the next cycle; no addresses issue.
  - RUN: issues addresses (rules below).
  - DONE: one cycle; done=1; then IDLE.
- can_count = (state==RUN) && rd_ready && (offset < wr_count).
- Advance = load_en && can_count. load_en alone never advances, because the controller holds the strobe high in its Count state even after can_count drops.
- On an advance:
  - rd_addr <= (base_ptr + offset) mod 2^ADDR_W; rd_valid <= 1. Latency is 1 cycle.
  - If offset == filter_size-1: offset <= 0; base_ptr <= (base_ptr + stride) mod 2^ADDR_W; win_cnt++; window_done and free_en pulse with rd_valid; free_cnt = stride.
  - If win_cnt was num_windows-1 at that point: go to DONE.
  - Otherwise: offset++.
- No advance: rd_valid <= 0 and all counters hold.
- Wrap-around: all address arithmetic is modulo 2^ADDR_W, with no bubble at the wrap.
- wr_count contract: the writer must subtract free_cnt from wr_count the cycle after free_en. Until then, the offset < wr_count test sees the pre-release count; because offset has already returned to 0, this is safe.
- filter_size > 2^ADDR_W is illegal and its behaviour is unspecified; the bench must not drive it.
- start while in RUN or DONE is ignored.
- rst during RUN: abandons the job immediately. No done and no free_en pulse; all outputs take their reset values on the next edge.

Optional Feature:
- Macro: WINDOW_ADDR_GEN_STALL_CNT_EN.
- When defined: adds output port stall_cycles (16 bits), a saturating count of RUN cycles with can_count==0. It clears on the cycle a new job is accepted from IDLE and on rst, and holds its value after done.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package addr_gen_pkg:
  - state encoding IDLE/RUN/DONE as a 2-bit enum;
  - default widths ADDR_W=4, SIZE_W=4, WIN_W=8.
- One natural sub-module, circ_ptr_add: combinational modulo-2^ADDR_W adder, instantiated for both base_ptr+offset and base_ptr+stride.

Test Plan:
- Basic job: filter_size=3, stride=1, num_windows=2, wr_count=16, rd_ready=1, load_en=1 -> rd_addr sequence 0,1,2,1,2,3. window_done on the 3rd and 6th rd_valid; free_en twice with free_cnt=1; done 1 cycle after the last rd_valid.
- Wrap: ADDR_W=4, filter_size=4, stride=4, num_windows=5 -> 5th window reads addresses 0,1,2,3 after 12..15 with no gap.
- Starvation: wr_count=2, filter_size=3 -> addresses 0,1 issue, then can_count=0 and no advance even with load_en=1. Raising wr_count to 3 -> address 2 on the next cycle.
- Backpressure: rd_ready low for 4 cycles mid-window -> rd_valid=0, offset holds, sequence resumes unchanged. With WINDOW_ADDR_GEN_STALL_CNT_EN, stall_cycles=4.
- Degenerate/reset: start with stride=0 -> done next cycle, no rd_valid. rst asserted during window 2 -> all outputs 0 next cycle, no done; a following start restarts at address 0.

Source files
------------

// File: rtl/window_read_addr_gen_pkg.sv
// Shared definitions for the sliding-window read address generator:
// controller state encoding and default field widths.
package addr_gen_pkg;

    // Default widths: buffer address, filter_size/stride, window counter.
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned SIZE_W = 4;
    localparam int unsigned WIN_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width large enough to compare an offset, a buffer count and a
    // filter size without truncating any of them.
    function automatic int unsigned cmp_width(input int unsigned addr_w,
                                              input int unsigned size_w);
        return ((addr_w + 1) > size_w) ? (addr_w + 1) : size_w;
    endfunction

endpackage

// File: rtl/window_read_addr_gen_if.sv
// Job / buffer / read-port bundle of the window read address generator.
// master: the controller + buffer side; slave: the address generator.
interface window_read_addr_gen_if
    import addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = addr_gen_pkg::ADDR_W,
    parameter int unsigned SIZE_W = addr_gen_pkg::SIZE_W,
    parameter int unsigned WIN_W  = addr_gen_pkg::WIN_W
) ();

    // Job control
    logic              start;
    logic [SIZE_W-1:0] filter_size;
    logic [SIZE_W-1:0] stride;
    logic [WIN_W-1:0]  num_windows;
    logic              busy;
    logic              done;

    // Controller handshake
    logic              load_en;
    logic              can_count;

    // Buffer fill level and read port
    logic [ADDR_W:0]   wr_count;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              window_done;

    // Release path back to the buffer writer
    logic              free_en;
    logic [SIZE_W-1:0] free_cnt;

    modport master (
        output start, filter_size, stride, num_windows,
        output load_en, wr_count, rd_ready,
        input  busy, done, can_count,
        input  rd_addr, rd_valid, window_done,
        input  free_en, free_cnt
    );

    modport slave (
        input  start, filter_size, stride, num_windows,
        input  load_en, wr_count, rd_ready,
        output busy, done, can_count,
        output rd_addr, rd_valid, window_done,
        output free_en, free_cnt
    );

endinterface

// File: rtl/window_read_addr_gen_circ_ptr_add.sv
// Modulo-2^ADDR_W pointer adder for the circular input buffer.
// The second operand is resized to ADDR_W bits, so any carry out of the
// buffer address range is simply discarded (wrap with no bubble).
module circ_ptr_add #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned B_W    = 4
) (
    input  logic [ADDR_W-1:0] a_i,
    input  logic [B_W-1:0]    b_i,
    output logic [ADDR_W-1:0] sum_o
);

    logic [ADDR_W-1:0] b_mod;

    assign b_mod = ADDR_W'(b_i);
    assign sum_o = a_i + b_mod;

endmodule

// File: rtl/window_read_addr_gen.sv
// Sliding-window read address generator for a circular input buffer.
// Issues one read address per qualified cycle (load_en && can_count),
// walks filter_size reads per window, advances the window base by stride
// and releases stride entries back to the writer after every window.
// Optional build macro: WINDOW_ADDR_GEN_STALL_CNT_EN adds the 16-bit
// stall_cycles output (saturating count of RUN cycles with can_count low).
module window_read_addr_gen
    import addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = addr_gen_pkg::ADDR_W,
    parameter int unsigned SIZE_W = addr_gen_pkg::SIZE_W,
    parameter int unsigned WIN_W  = addr_gen_pkg::WIN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    window_read_addr_gen_if.slave  bus
`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cycles
`endif
);

    localparam int unsigned CMP_W = cmp_width(ADDR_W, SIZE_W);

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] offset_q;
    logic [WIN_W-1:0]  win_cnt_q;
    logic [SIZE_W-1:0] fsize_q;
    logic [SIZE_W-1:0] stride_q;
    logic [WIN_W-1:0]  nwin_q;

    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_valid_q;
    logic              window_done_q;
    logic              free_en_q;
    logic [SIZE_W-1:0] free_cnt_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W-1:0] rd_addr_d;
    logic [ADDR_W-1:0] base_d;
    logic              can_count;
    logic              advance;
    logic              last_offset;
    logic              last_window;
    logic              start_ok;

    // Current read address: window base plus offset, wrapped.
    circ_ptr_add #(
        .ADDR_W (ADDR_W),
        .B_W    (ADDR_W)
    ) u_addr_add (
        .a_i   (base_q),
        .b_i   (offset_q),
        .sum_o (rd_addr_d)
    );

    // Next window base: base plus latched stride, wrapped.
    circ_ptr_add #(
        .ADDR_W (ADDR_W),
        .B_W    (SIZE_W)
    ) u_base_add (
        .a_i   (base_q),
        .b_i   (stride_q),
        .sum_o (base_d)
    );

    // Issue qualifier and window/job boundary decodes.
    always_comb begin
        can_count   = (state_q == RUN) && bus.rd_ready
                      && (CMP_W'(offset_q) < CMP_W'(bus.wr_count));
        // load_en is held high by the controller even when can_count is
        // low, so only the qualified strobe moves the counters.
        advance     = bus.load_en && can_count;
        last_offset = (CMP_W'(offset_q) + CMP_W'(1)) == CMP_W'(fsize_q);
        last_window = (win_cnt_q + WIN_W'(1)) == nwin_q;
        start_ok    = (bus.filter_size != '0) && (bus.stride != '0)
                      && (bus.num_windows != '0);
    end

    // Job FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            offset_q      <= '0;
            win_cnt_q     <= '0;
            fsize_q       <= '0;
            stride_q      <= '0;
            nwin_q        <= '0;
            rd_addr_q     <= '0;
            rd_valid_q    <= 1'b0;
            window_done_q <= 1'b0;
            free_en_q     <= 1'b0;
            free_cnt_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            rd_valid_q    <= 1'b0;
            window_done_q <= 1'b0;
            free_en_q     <= 1'b0;
            done_q        <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (start_ok) begin
                            fsize_q   <= bus.filter_size;
                            stride_q  <= bus.stride;
                            nwin_q    <= bus.num_windows;
                            base_q    <= '0;
                            offset_q  <= '0;
                            win_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= RUN;
                        end else begin
                            // Empty job: report completion without issuing.
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (advance) begin
                        rd_addr_q  <= rd_addr_d;
                        rd_valid_q <= 1'b1;
                        if (last_offset) begin
                            offset_q      <= '0;
                            base_q        <= base_d;
                            win_cnt_q     <= win_cnt_q + WIN_W'(1);
                            window_done_q <= 1'b1;
                            free_en_q     <= 1'b1;
                            free_cnt_q    <= stride_q;
                            if (last_window) begin
                                busy_q  <= 1'b0;
                                state_q <= DONE;
                            end
                        end else begin
                            offset_q <= offset_q + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    // done lands one cycle after the final rd_valid.
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of RUN cycles in which no address could issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && bus.start && start_ok) begin
            stall_q <= '0;
        end else if ((state_q == RUN) && !can_count && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign bus.can_count   = can_count;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.window_done = window_done_q;
    assign bus.free_en     = free_en_q;
    assign bus.free_cnt    = free_cnt_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_window_read_addr_gen.sv
// Bench for window_read_addr_gen: directed scenarios with literal address
// sequences, then randomized stimulus against a job-level reference model.
module tb_window_read_addr_gen;

    logic clk;
    logic rst;
    logic chk_en;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   done_cyc;

    window_read_addr_gen_if #(.ADDR_W(4), .SIZE_W(4), .WIN_W(8)) bus ();

`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    window_read_addr_gen #(.ADDR_W(4), .SIZE_W(4), .WIN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: the k-th read of a job sits in window k/fs at offset k%fs.
    function automatic int unsigned model_addr(input int unsigned k, input int unsigned fs,
                                               input int unsigned st);
        return ((k / fs) * st + (k % fs)) % 16;
    endfunction

    // Model state: job fields, reads issued, running / finishing flags.
    int unsigned m_fs, m_st, m_nw, m_k, m_total, m_off, m_stall;
    bit          m_run, m_fin, m_cc;
    logic [3:0]  e_addr = '0;
    logic [3:0]  e_fc   = '0;
    bit          e_valid, e_wd, e_fe, e_done, e_busy;

    // Compare outputs against the model, then step the model to the next edge.
    always @(negedge clk) begin
        if (chk_en) begin
            m_off = m_run ? (m_k % m_fs) : 0;
            m_cc  = m_run && (bus.rd_ready === 1'b1) && (m_off < bus.wr_count);
            chk("can_count", bus.can_count, m_cc);
            chk("rd_valid", bus.rd_valid, e_valid);
            chk("rd_addr", bus.rd_addr, e_addr);
            chk("window_done", bus.window_done, e_wd);
            chk("free_en", bus.free_en, e_fe);
            chk("free_cnt", bus.free_cnt, e_fc);
            chk("done", bus.done, e_done);
            chk("busy", bus.busy, e_busy);
`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
            chk("stall_cycles", stall_cycles, m_stall);
`endif
            if (rst) begin
                m_run = 0; m_fin = 0; m_k = 0; m_stall = 0;
                e_valid = 0; e_wd = 0; e_fe = 0; e_done = 0; e_busy = 0;
                e_addr = '0; e_fc = '0;
            end else begin
                e_valid = 0; e_wd = 0; e_fe = 0; e_done = 0;
                if (m_fin) begin
                    e_done = 1;
                    m_fin  = 0;
                end else if (!m_run) begin
                    if (bus.start) begin
                        if (bus.filter_size != 0 && bus.stride != 0 && bus.num_windows != 0) begin
                            m_fs = bus.filter_size; m_st = bus.stride; m_nw = bus.num_windows;
                            m_total = m_fs * m_nw; m_k = 0; m_run = 1; e_busy = 1; m_stall = 0;
                        end else begin
                            e_done = 1;
                        end
                    end
                end else begin
                    if (!m_cc && m_stall < 65535) m_stall++;
                    if (bus.load_en && m_cc) begin
                        e_valid = 1;
                        e_addr  = 4'(model_addr(m_k, m_fs, m_st));
                        if (m_off == m_fs - 1) begin
                            e_wd = 1; e_fe = 1; e_fc = 4'(m_st);
                        end
                        m_k++;
                        if (m_k == m_total) begin
                            m_run = 0; m_fin = 1; e_busy = 0;
                        end
                    end
                end
            end
        end
    end

    // Record every issued address with its cycle and window_done flag.
    int unsigned cap_addr[$];
    int          cap_cyc[$];
    bit          cap_wd[$];
    always @(negedge clk) begin
        if (chk_en && bus.rd_valid === 1'b1) begin
            cap_addr.push_back(bus.rd_addr);
            cap_cyc.push_back(cyc);
            cap_wd.push_back(bus.window_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_addr.delete();
        cap_cyc.delete();
        cap_wd.delete();
    endtask

    task automatic pulse_start(input int fs, input int st, input int nw);
        bus.filter_size = 4'(fs);
        bus.stride      = 4'(st);
        bus.num_windows = 8'(nw);
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen     = 1;
                done_cyc = cyc;
            end
        end
        chk("done_seen", seen, 1);
        tick();
    endtask

    task automatic chk_seq(input string nm, input int unsigned exp[$]);
        chk({nm, "_len"}, cap_addr.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap_addr.size(); i++)
            chk({nm, "_addr"}, cap_addr[i], exp[i]);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; done_cyc = 0; chk_en = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0; bus.filter_size = '0; bus.stride = '0; bus.num_windows = '0;
        bus.wr_count = 5'd16; bus.rd_ready = 1'b1; bus.load_en = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_rd_valid", bus.rd_valid, 0);
        chk("reset_rd_addr", bus.rd_addr, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        rst = 1'b0;
        tick();

        // Basic job: two windows of three, stride 1.
        clear_cap();
        pulse_start(3, 1, 2);
        wait_done(40);
        chk_seq("basic", '{0, 1, 2, 1, 2, 3});
        chk("basic_wd3", cap_wd[2], 1);
        chk("basic_wd6", cap_wd[5], 1);
        chk("basic_wd1", cap_wd[0], 0);
        chk("basic_done_lat", done_cyc - cap_cyc[cap_cyc.size() - 1], 1);

        // Wrap: fifth window returns to address 0 with no gap.
        clear_cap();
        pulse_start(4, 4, 5);
        wait_done(60);
        chk("wrap_len", cap_addr.size(), 20);
        begin
            int unsigned tail[$] = '{12, 13, 14, 15, 0, 1, 2, 3};
            for (int i = 0; i < 8; i++) chk("wrap_addr", cap_addr[12 + i], tail[i]);
        end
        chk("wrap_no_gap", cap_cyc[19] - cap_cyc[0], 19);

        // Starvation: only two entries available.
        clear_cap();
        bus.wr_count = 5'd2;
        pulse_start(3, 1, 1);
        repeat (5) tick();
        chk("starve_len", cap_addr.size(), 2);
        chk("starve_can_count", bus.can_count, 0);
        bus.wr_count = 5'd3;
        tick();
        chk("starve_resume_valid", bus.rd_valid, 1);
        chk("starve_resume_addr", bus.rd_addr, 2);
        wait_done(20);
        chk_seq("starve", '{0, 1, 2});
        bus.wr_count = 5'd16;

        // Backpressure: rd_ready low for four cycles mid-window.
        clear_cap();
        pulse_start(4, 2, 2);
        tick();
        tick();
        bus.rd_ready = 1'b0;
        repeat (4) tick();
        bus.rd_ready = 1'b1;
        wait_done(40);
        chk_seq("bp", '{0, 1, 2, 3, 2, 3, 4, 5});
`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
        chk("bp_stall", stall_cycles, 4);
`endif

        // Degenerate start: zero stride completes immediately.
        clear_cap();
        pulse_start(3, 0, 2);
        chk("degen_done", bus.done, 1);
        tick();
        chk("degen_no_valid", cap_addr.size(), 0);
        chk("degen_busy", bus.busy, 0);

        // Reset while in the second window abandons the job.
        clear_cap();
        pulse_start(3, 1, 3);
        for (int i = 0; i < 30 && cap_addr.size() < 4; i++) tick();
        chk("rst_in_w2", cap_addr.size() >= 4, 1);
        rst = 1'b1;
        tick();
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_free_en", bus.free_en, 0);
        chk("rst_free_cnt", bus.free_cnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (3) tick();
        clear_cap();
        pulse_start(3, 1, 3);
        wait_done(40);
        chk_seq("restart", '{0, 1, 2, 1, 2, 3, 2, 3, 4});

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            rst             = ($urandom_range(0, 399) == 0);
            bus.start       = ($urandom_range(0, 7) == 0);
            bus.filter_size = 4'($urandom_range(0, 15));
            bus.stride      = 4'($urandom_range(0, 15));
            bus.num_windows = 8'($urandom_range(0, 5));
            bus.wr_count    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 16)) : 5'd16;
            bus.rd_ready    = ($urandom_range(0, 9) != 0);
            bus.load_en     = ($urandom_range(0, 7) != 0);
            tick();
        end
        rst = 1'b0;
        bus.start = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
